jzjpcc_mmio_ports: RTL and testbench

Parametrised memory-mapped IO port bank for the jzjpcc core. It replaces the fixed 8-in/8-out word ports with NUM_PORTS bidirectional 32-bit ports. Each port has a per-bit direction register, byte-enable writes, an input synchronizer and a registered read path. It sits beside the memory backend, which routes any access with hit=1 here instead of to SRAM.

---
 rtl/jzjpcc_mmio_ports.sv | 140 ++++++++++++++
 tb/tb_jzjpcc_mmio_ports.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_mmio_ports.sv
// Memory-mapped bank of NUM_PORTS bidirectional 32-bit IO ports for the jzjpcc core.
// Optional input-change interrupt and status word are enabled with JZJPCC_MMIO_CHANGE_IRQ_EN.
module jzjpcc_mmio_ports #(
  parameter int NUM_PORTS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [29:0]                 address,
  input  logic                        readEnable,
  input  logic                        writeEnable,
  input  logic [3:0]                  byteEnable,
  input  logic [31:0]                 writeData,
  output logic                        hit,
  output logic [31:0]                 readData,
  input  logic [NUM_PORTS-1:0][31:0]  mmioInputs,
  output logic [NUM_PORTS-1:0][31:0]  mmioOutputs,
  output logic [NUM_PORTS-1:0][31:0]  mmioDirection,
  output logic                        changeIrq
);

  // Requests are single-cycle and never back-pressured: readEnable/writeEnable act
  // only when hit=1, writes land on the next edge, reads appear one edge later.

  localparam logic [29:0] BASE_W = 30'((1 << 30) - 2 * NUM_PORTS);

  logic                        in_range;
  logic [29:0]                 off;
  logic [NUM_PORTS-1:0]        dir_hit;
  logic [NUM_PORTS-1:0]        data_hit;
  logic                        status_hit;
  logic [31:0]                 lane_mask;
  logic [31:0]                 rd_val;
  logic [31:0]                 pending_word;
  logic [NUM_PORTS-1:0][31:0]  sync_in;

  assign in_range  = (address >= BASE_W);
  assign off       = address - BASE_W;
  assign lane_mask = {{8{byteEnable[3]}}, {8{byteEnable[2]}},
                      {8{byteEnable[1]}}, {8{byteEnable[0]}}};

  always_comb begin
    dir_hit  = '0;
    data_hit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      dir_hit[i]  = in_range && (off == 30'(i));
      data_hit[i] = in_range && (off == 30'(NUM_PORTS + i));
    end
  end

  assign hit = (|dir_hit) | (|data_hit) | status_hit;

  // Data reads return the driven value on output bits and the synchronized pin on input bits.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (dir_hit[i]) rd_val = mmioDirection[i];
      if (data_hit[i]) rd_val = (mmioDirection[i] & mmioOutputs[i]) |
                                (~mmioDirection[i] & sync_in[i]);
    end
    if (status_hit) rd_val = pending_word;
  end

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign sync_in = mmioInputs;
    end else begin : g_sync
      logic [NUM_PORTS-1:0][31:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
          sync_q[0] <= mmioInputs;
          for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
      end
      assign sync_in = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      readData      <= '0;
      mmioOutputs   <= '0;
      mmioDirection <= '0;
    end else begin
      if (readEnable && hit) readData <= rd_val;
      if (writeEnable) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (dir_hit[i])
            mmioDirection[i] <= (mmioDirection[i] & ~lane_mask) | (writeData & lane_mask);
          if (data_hit[i])
            mmioOutputs[i] <= (mmioOutputs[i] & ~lane_mask) | (writeData & lane_mask);
        end
      end
    end
  end

`ifdef JZJPCC_MMIO_CHANGE_IRQ_EN
  localparam logic [29:0] STATUS_W = BASE_W - 30'd1;

  logic [NUM_PORTS-1:0][31:0] prev_in;
  logic [NUM_PORTS-1:0]       pending;
  logic [NUM_PORTS-1:0]       pend_set;
  logic [NUM_PORTS-1:0]       pend_clr;
  logic                       irq_q;

  assign status_hit = (address == STATUS_W);

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      pend_set[i] = |((sync_in[i] ^ prev_in[i]) & ~mmioDirection[i]);
    if (writeEnable && status_hit)
      pend_clr = writeData[NUM_PORTS-1:0] & lane_mask[NUM_PORTS-1:0];
  end

  // Set is ORed in after the clear so a change on the clear edge is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_in <= '0;
      pending <= '0;
      irq_q   <= 1'b0;
    end else begin
      prev_in <= sync_in;
      pending <= (pending & ~pend_clr) | pend_set;
      irq_q   <= |pending;
    end
  end

  assign pending_word = 32'(pending);
  assign changeIrq    = irq_q;
`else
  assign status_hit   = 1'b0;
  assign pending_word = '0;
  assign changeIrq    = 1'b0;
`endif

endmodule

// File: tb/tb_jzjpcc_mmio_ports.sv
// Self-checking bench for jzjpcc_mmio_ports: directed scenarios plus randomized traffic
// against a behavioural model of the port bank (honours JZJPCC_MMIO_CHANGE_IRQ_EN).
module tb_jzjpcc_mmio_ports;
  localparam int NP = 8;
  localparam int SS = 2;
  typedef logic [NP-1:0][31:0] bank_t;

  logic        clock;
  logic        reset;
  logic [29:0] address;
  logic        readEnable;
  logic        writeEnable;
  logic [3:0]  byteEnable;
  logic [31:0] writeData;
  logic        hit;
  logic [31:0] readData;
  bank_t       mmioInputs;
  bank_t       mmioOutputs;
  bank_t       mmioDirection;
  logic        changeIrq;

  jzjpcc_mmio_ports #(.NUM_PORTS(NP), .SYNC_STAGES(SS)) dut (
    .clock(clock), .reset(reset), .address(address), .readEnable(readEnable),
    .writeEnable(writeEnable), .byteEnable(byteEnable), .writeData(writeData),
    .hit(hit), .readData(readData), .mmioInputs(mmioInputs),
    .mmioOutputs(mmioOutputs), .mmioDirection(mmioDirection), .changeIrq(changeIrq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bank_t       m_out, m_dir, m_prev;
  logic [31:0] m_rd;
  logic [NP-1:0] m_pend;
  logic        m_irq;
  bank_t       sync_hist[$];

  // 0 = unmapped, 1 = direction, 2 = data, 3 = status
  function automatic int decode(input logic [29:0] a, output int idx);
    longint b, base;
    b = longint'({32'd0, a, 2'b00});
    base = 64'h1_0000_0000 - 8 * NP;
    idx = 0;
    if (b >= base) begin
      idx = int'((b - base) / 4);
      if (idx < NP) return 1;
      idx = idx - NP;
      return 2;
    end
`ifdef JZJPCC_MMIO_CHANGE_IRQ_EN
    if (b == base - 4) return 3;
`endif
    return 0;
  endfunction

  task automatic model_step();
    bank_t s_now;
    int k, idx;
    logic [NP-1:0] set_v, clr_v;
    if (reset) begin
      m_out = '0; m_dir = '0; m_prev = '0; m_rd = '0; m_pend = '0; m_irq = 1'b0;
      sync_hist.delete();
      for (int s = 0; s < SS; s++) sync_hist.push_back('0);
    end else begin
      s_now = (SS == 0) ? mmioInputs : sync_hist[0];
      k = decode(address, idx);
      if (readEnable && k != 0) begin
        case (k)
          1: m_rd = m_dir[idx];
          2: for (int b = 0; b < 32; b++)
               m_rd[b] = m_dir[idx][b] ? m_out[idx][b] : s_now[idx][b];
          default: m_rd = 32'(m_pend);
        endcase
      end
      set_v = '0;
      clr_v = '0;
`ifdef JZJPCC_MMIO_CHANGE_IRQ_EN
      for (int p = 0; p < NP; p++)
        for (int b = 0; b < 32; b++)
          if (!m_dir[p][b] && s_now[p][b] != m_prev[p][b]) set_v[p] = 1'b1;
      if (writeEnable && k == 3)
        for (int p = 0; p < NP; p++)
          if (byteEnable[p / 8] && writeData[p]) clr_v[p] = 1'b1;
      m_irq = (m_pend != 0);
      m_pend = (m_pend & ~clr_v) | set_v;
      m_prev = s_now;
`endif
      if (writeEnable) begin
        for (int n = 0; n < 4; n++) begin
          if (byteEnable[n] && k == 1) m_dir[idx][8*n +: 8] = writeData[8*n +: 8];
          if (byteEnable[n] && k == 2) m_out[idx][8*n +: 8] = writeData[8*n +: 8];
        end
      end
      if (SS > 0) begin
        sync_hist.push_back(mmioInputs);
        void'(sync_hist.pop_front());
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic re, input logic we, input logic [31:0] ba,
                       input logic [3:0] be, input logic [31:0] wd);
    readEnable = re; writeEnable = we; address = ba[31:2]; byteEnable = be; writeData = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 32'hFFFF_FFE0, 4'hF, 32'hDEAD_BEEF);
    tick();
    tick();
    if (mmioOutputs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", mmioOutputs); end
    checks++;
    if (mmioDirection !== '0) begin failures++; $display("FAIL reset_dir got=%h exp=0", mmioDirection); end
    checks++;
    if (readData !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", readData); end
    checks++;
    if (changeIrq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", changeIrq); end
    checks++;
    reset = 1'b0;
    idle();
    address = 30'h3FFF_FFF8;
    #1;
    if (hit !== 1'b1) begin failures++; $display("FAIL hit_data0 got=%b exp=1", hit); end
    checks++;
  endtask

  task automatic test_sync_latency();
    logic [31:0] exp_c;
    mmioInputs[0] = 32'hA5A5_0001;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 32'hFFFF_FFE0, 4'h0, 32'h0);
      tick();
      exp_c = (c >= 2) ? 32'hA5A5_0001 : 32'h0000_0000;
      if (readData !== exp_c) begin failures++; $display("FAIL sync_read_c%0d got=%h exp=%h", c, readData, exp_c); end
      checks++;
      if (readData !== m_rd) begin failures++; $display("FAIL sync_model_c%0d got=%h exp=%h", c, readData, m_rd); end
      checks++;
    end
    idle();
  endtask

  task automatic test_byte_enable();
    drive(1'b1, 1'b1, 32'hFFFF_FFE4, 4'b0101, 32'h1122_3344);
    tick();
    idle();
    if (mmioOutputs[1] !== 32'h0022_0044) begin failures++; $display("FAIL be_write got=%h exp=00220044", mmioOutputs[1]); end
    checks++;
    if (readData !== 32'h0) begin failures++; $display("FAIL be_rd_prewrite got=%h exp=00000000", readData); end
    checks++;
    drive(1'b0, 1'b1, 32'hFFFF_FFE4, 4'b0000, 32'hFFFF_FFFF);
    tick();
    idle();
    if (mmioOutputs !== m_out) begin failures++; $display("FAIL be_zero_noop got=%h exp=%h", mmioOutputs, m_out); end
    checks++;
  endtask

  task automatic test_direction_mix();
    mmioInputs[2] = 32'hAAAA_5555;
    drive(1'b0, 1'b1, 32'hFFFF_FFC8, 4'hF, 32'h0000_FFFF);
    tick();
    drive(1'b0, 1'b1, 32'hFFFF_FFE8, 4'hF, 32'h1234_5678);
    tick();
    drive(1'b1, 1'b0, 32'hFFFF_FFE8, 4'h0, 32'h0);
    tick();
    idle();
    if (readData !== 32'hAAAA_5678) begin failures++; $display("FAIL mix_read got=%h exp=AAAA5678", readData); end
    checks++;
    if (mmioDirection[2] !== 32'h0000_FFFF) begin failures++; $display("FAIL mix_dir got=%h exp=0000FFFF", mmioDirection[2]); end
    checks++;
    drive(1'b1, 1'b0, 32'hFFFF_FFC8, 4'h0, 32'h0);
    tick();
    idle();
    if (readData !== 32'h0000_FFFF) begin failures++; $display("FAIL mix_dir_read got=%h exp=0000FFFF", readData); end
    checks++;
  endtask

  task automatic test_unmapped();
    logic [31:0] rd_before;
    logic [31:0] addrs [2];
    int idx;
    logic exp_hit;
    addrs[0] = 32'h0000_0100;
    addrs[1] = 32'hFFFF_FFBC;
    for (int j = 0; j < 2; j++) begin
      rd_before = readData;
      drive(1'b1, 1'b1, addrs[j], 4'hF, 32'h0000_0000);
      #1;
      exp_hit = (decode(address, idx) != 0);
`ifndef JZJPCC_MMIO_CHANGE_IRQ_EN
      if (hit !== 1'b0) begin failures++; $display("FAIL unmapped_hit_%0d got=%b exp=0", j, hit); end
      checks++;
`endif
      if (hit !== exp_hit) begin failures++; $display("FAIL unmapped_hit_model_%0d got=%b exp=%b", j, hit, exp_hit); end
      checks++;
      tick();
      idle();
      if (mmioOutputs !== m_out || mmioDirection !== m_dir) begin
        failures++; $display("FAIL unmapped_regs_%0d got=%h/%h exp=%h/%h", j, mmioOutputs, mmioDirection, m_out, m_dir);
      end
      checks++;
      if (!exp_hit && readData !== rd_before) begin failures++; $display("FAIL unmapped_rd_hold_%0d got=%h exp=%h", j, readData, rd_before); end
      checks++;
    end
  endtask

  task automatic test_random();
    logic [31:0] ba;
    int idx;
    logic exp_hit;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) < 8) ba = 32'hFFFF_FFBC + 32'(4 * $urandom_range(0, 16));
      else ba = $urandom & 32'hFFFF_FFFC;
      drive(1'($urandom), 1'($urandom), ba, 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0)
        for (int p = 0; p < NP; p++) mmioInputs[p] = $urandom;
      #1;
      exp_hit = (decode(address, idx) != 0);
      if (hit !== exp_hit) begin failures++; $display("FAIL rnd_hit n=%0d got=%b exp=%b", n, hit, exp_hit); end
      checks++;
      tick();
      if (readData !== m_rd) begin failures++; $display("FAIL rnd_rd n=%0d got=%h exp=%h", n, readData, m_rd); end
      checks++;
      if (mmioOutputs !== m_out) begin failures++; $display("FAIL rnd_out n=%0d got=%h exp=%h", n, mmioOutputs, m_out); end
      checks++;
      if (mmioDirection !== m_dir) begin failures++; $display("FAIL rnd_dir n=%0d got=%h exp=%h", n, mmioDirection, m_dir); end
      checks++;
      if (changeIrq !== m_irq) begin failures++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, changeIrq, m_irq); end
      checks++;
    end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_reset_midop();
    drive(1'b0, 1'b1, 32'hFFFF_FFE0, 4'hF, 32'hFFFF_FFFF);
    tick();
    if (mmioOutputs[0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL midop_pre got=%h exp=FFFFFFFF", mmioOutputs[0]); end
    checks++;
    drive(1'b1, 1'b1, 32'hFFFF_FFE4, 4'hF, 32'h5555_5555);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    if (mmioOutputs !== '0 || mmioDirection !== '0 || readData !== 32'h0 || changeIrq !== 1'b0) begin
      failures++; $display("FAIL midop_reset got=%h/%h/%h/%b exp=all zero", mmioOutputs, mmioDirection, readData, changeIrq);
    end
    checks++;
  endtask

`ifdef JZJPCC_MMIO_CHANGE_IRQ_EN
  task automatic test_change_irq();
    reset = 1'b1;
    mmioInputs = '0;
    idle();
    tick();
    reset = 1'b0;
    mmioInputs[3] = 32'h0000_0001;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (changeIrq !== (e == 4)) begin failures++; $display("FAIL irq_edge%0d got=%b exp=%b", e, changeIrq, (e == 4)); end
      checks++;
    end
    drive(1'b1, 1'b0, 32'hFFFF_FFBC, 4'h0, 32'h0);
    tick();
    if (readData !== 32'h0000_0008) begin failures++; $display("FAIL irq_status got=%h exp=00000008", readData); end
    checks++;
    drive(1'b0, 1'b1, 32'hFFFF_FFBC, 4'h1, 32'h0000_0008);
    tick();
    idle();
    tick();
    if (changeIrq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", changeIrq); end
    checks++;
    mmioInputs[3] = 32'h0;
    tick(); tick(); tick();
    mmioInputs[3] = 32'h0000_0001;
    tick(); tick();
    drive(1'b0, 1'b1, 32'hFFFF_FFBC, 4'h1, 32'h0000_0008);
    tick();
    drive(1'b1, 1'b0, 32'hFFFF_FFBC, 4'h0, 32'h0);
    tick();
    idle();
    if (readData !== 32'h0000_0008) begin failures++; $display("FAIL irq_set_wins got=%h exp=00000008", readData); end
    checks++;
    if (changeIrq !== m_irq || readData !== m_rd) begin
      failures++; $display("FAIL irq_model got=%b/%h exp=%b/%h", changeIrq, readData, m_irq, m_rd);
    end
    checks++;
  endtask
`endif

  initial begin
    reset = 1'b1;
    mmioInputs = '0;
    idle();
    test_reset();
    test_sync_latency();
    test_byte_enable();
    test_direction_mix();
    test_unmapped();
    test_reset_midop();
`ifdef JZJPCC_MMIO_CHANGE_IRQ_EN
    test_change_irq();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
